// File: rtl/dcls_pkg.sv
`default_nettype none
// dcls_pkg: shared FSM state encoding and internal counter widths for the DCLS lockstep checker.
package dcls_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOCKED  = 2'd1,
      ST_SUSPECT = 2'd2,
      ST_FAULT   = 2'd3
   } dcls_state_e;

   // Sized to cover the largest legal MISMATCH_THRESH (15) and RECOVER_MATCHES (255).
   localparam int unsigned SUS_W = 4;
   localparam int unsigned RUN_W = 8;

endpackage
`default_nettype wire

// File: rtl/dcls_delay_line.sv
`default_nettype none
// dcls_delay_line: DEPTH-stage shift register; valid bits clear on reset or flush, data is never reset.
module dcls_delay_line #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   logic [DEPTH-1:0] valid_q;
   logic [WIDTH-1:0] data_q [DEPTH];

   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         valid_q <= '0;
      end else begin
         valid_q[0] <= in_valid;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
         end
      end
   end

   // Payload only matters where the matching valid bit is set.
   always_ff @(posedge clk) begin
      data_q[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
         data_q[i] <= data_q[i-1];
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_data  = data_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/dcls_lockstep_checker.sv
`default_nettype none
// dcls_lockstep_checker: aligns the master stream to the shadow core, compares NUM_CH channels per beat
// and runs a tolerant fault FSM with sticky channel mask and saturating mismatch counter.
module dcls_lockstep_checker #(
   parameter int unsigned DATA_W          = 32,
   parameter int unsigned NUM_CH          = 2,
   parameter int unsigned DELAY_CYCLES    = 2,
   parameter int unsigned MISMATCH_THRESH = 3,
   parameter int unsigned RECOVER_MATCHES = 8,
   parameter int unsigned CNT_W           = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     master_valid,
   input  logic [NUM_CH*DATA_W-1:0] master_data,
   input  logic                     shadow_valid,
   input  logic [NUM_CH*DATA_W-1:0] shadow_data,
   input  logic                     strict_mode,
   input  logic                     clear_fault,
   output logic                     lockstep_ok,
   output logic                     mismatch_pulse,
   output logic                     sync_error,
   output logic                     fault,
   output logic [NUM_CH-1:0]        fault_ch_mask,
   output logic [CNT_W-1:0]         mismatch_count,
   output logic [1:0]               fsm_state
);
   import dcls_pkg::*;

   localparam logic [SUS_W:0] THRESH_V  = (SUS_W+1)'(MISMATCH_THRESH);
   localparam logic [RUN_W:0] RECOVER_V = (RUN_W+1)'(RECOVER_MATCHES);

   dcls_state_e             state, state_nxt;
   logic [SUS_W-1:0]        sus_cnt, sus_nxt;
   logic [RUN_W-1:0]        match_run, run_nxt;
   logic [SUS_W:0]          sus_inc;
   logic [RUN_W:0]          run_inc;
   logic                    d_valid;
   logic [NUM_CH*DATA_W-1:0] d_data;
   logic                    both_valid, one_valid, mis, flush;
   logic [NUM_CH-1:0]       ch_mis;

   assign flush = clear_fault && (state == ST_FAULT);

   dcls_delay_line #(
      .WIDTH (NUM_CH*DATA_W),
      .DEPTH (DELAY_CYCLES)
   ) u_delay (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (master_valid),
      .in_data   (master_data),
      .out_valid (d_valid),
      .out_data  (d_data)
   );

   assign both_valid = d_valid & shadow_valid;
   assign one_valid  = d_valid ^ shadow_valid;

   // A one-sided beat blames every channel since nothing can be compared.
   generate
      for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
         assign ch_mis[c] = both_valid ?
            (|(d_data[c*DATA_W +: DATA_W] ^ shadow_data[c*DATA_W +: DATA_W])) : one_valid;
      end
   endgenerate

   assign mis     = |ch_mis;
   assign sus_inc = {1'b0, sus_cnt} + (SUS_W+1)'(1);
   assign run_inc = {1'b0, match_run} + (RUN_W+1)'(1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         sus_cnt   <= '0;
         match_run <= '0;
      end else begin
         state     <= state_nxt;
         sus_cnt   <= sus_nxt;
         match_run <= run_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sus_nxt   = sus_cnt;
      run_nxt   = match_run;
      // clear_fault discards the current beat entirely.
      if (clear_fault) begin
         if (state == ST_FAULT) begin
            state_nxt = ST_IDLE;
            sus_nxt   = '0;
            run_nxt   = '0;
         end
      end else if (mis) begin
         case (state)
            ST_IDLE, ST_LOCKED: begin
               if (strict_mode || (MISMATCH_THRESH <= 1)) begin
                  state_nxt = ST_FAULT;
               end else begin
                  state_nxt = ST_SUSPECT;
                  sus_nxt   = SUS_W'(1);
                  run_nxt   = '0;
               end
            end
            ST_SUSPECT: begin
               if (strict_mode || (sus_inc >= THRESH_V)) begin
                  state_nxt = ST_FAULT;
               end else begin
                  sus_nxt = sus_inc[SUS_W-1:0];
                  run_nxt = '0;
               end
            end
            default: ;
         endcase
      end else if (both_valid) begin
         case (state)
            ST_IDLE: state_nxt = ST_LOCKED;
            ST_SUSPECT: begin
               if (run_inc == RECOVER_V) begin
                  state_nxt = ST_LOCKED;
                  sus_nxt   = '0;
                  run_nxt   = '0;
               end else begin
                  run_nxt = run_inc[RUN_W-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         mismatch_pulse <= 1'b0;
         sync_error     <= 1'b0;
         fault_ch_mask  <= '0;
         mismatch_count <= '0;
      end else begin
         mismatch_pulse <= mis & ~clear_fault;
         sync_error     <= one_valid & ~clear_fault;
         if (clear_fault) begin
            fault_ch_mask <= '0;
         end else if (mis) begin
            fault_ch_mask <= fault_ch_mask | ch_mis;
            if (mismatch_count != '1) begin
               mismatch_count <= mismatch_count + CNT_W'(1);
            end
         end
      end
   end

   assign lockstep_ok = (state == ST_LOCKED);
   assign fault       = (state == ST_FAULT);
   assign fsm_state   = state;

endmodule
`default_nettype wire

// File: tb/tb_dcls_lockstep_checker.sv
`default_nettype none
// tb_dcls_lockstep_checker: directed scenarios plus random traffic, checked every cycle against a
// queue-based reference model of the lockstep checker.
module tb_dcls_lockstep_checker;

   localparam int THRESH  = 3;
   localparam int RECOVER = 8;
   localparam int DELAY   = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        master_valid = 1'b0, shadow_valid = 1'b0;
   logic [63:0] master_data = '0, shadow_data = '0;
   logic        strict_mode = 1'b0, clear_fault = 1'b0;

   logic        lockstep_ok, mismatch_pulse, sync_error, fault;
   logic [1:0]  fault_ch_mask, fsm_state;
   logic [15:0] mismatch_count;
   logic        ok4, pulse4, serr4, fault4;
   logic [1:0]  mask4, state4;
   logic [3:0]  count4;

   always #5 clk = ~clk;

   dcls_lockstep_checker #(.DATA_W(32), .NUM_CH(2), .DELAY_CYCLES(DELAY), .MISMATCH_THRESH(THRESH),
                           .RECOVER_MATCHES(RECOVER), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .master_valid(master_valid), .master_data(master_data),
      .shadow_valid(shadow_valid), .shadow_data(shadow_data), .strict_mode(strict_mode),
      .clear_fault(clear_fault), .lockstep_ok(lockstep_ok), .mismatch_pulse(mismatch_pulse),
      .sync_error(sync_error), .fault(fault), .fault_ch_mask(fault_ch_mask),
      .mismatch_count(mismatch_count), .fsm_state(fsm_state));

   dcls_lockstep_checker #(.DATA_W(32), .NUM_CH(2), .DELAY_CYCLES(DELAY), .MISMATCH_THRESH(THRESH),
                           .RECOVER_MATCHES(RECOVER), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .master_valid(master_valid), .master_data(master_data),
      .shadow_valid(shadow_valid), .shadow_data(shadow_data), .strict_mode(strict_mode),
      .clear_fault(clear_fault), .lockstep_ok(ok4), .mismatch_pulse(pulse4),
      .sync_error(serr4), .fault(fault4), .fault_ch_mask(mask4),
      .mismatch_count(count4), .fsm_state(state4));

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int seq      = 1;

   // Reference model state
   int          m_st, m_sus, m_run, m_cnt, m_cnt4;
   logic [1:0]  m_mask;
   bit          m_pulse, m_serr;
   bit          hq_v[$];
   logic [63:0] hq_d[$];

   // Shadow stimulus history: index 0 = one cycle ago, 1 = two cycles ago
   bit          sh_v0, sh_v1;
   logic [63:0] sh_d0, sh_d1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_sus = 0; m_run = 0; m_cnt = 0; m_cnt4 = 0;
      m_mask = 2'b00; m_pulse = 0; m_serr = 0;
      hq_v.delete(); hq_d.delete();
      for (int i = 0; i < DELAY; i++) begin hq_v.push_back(1'b0); hq_d.push_back('0); end
   endtask

   task automatic model_step(input bit mv, input logic [63:0] md, input bit sv, input logic [63:0] sd,
                             input bit strict, input bit clr, input bit rstn);
      bit dv, mis, flush;
      logic [63:0] dd;
      logic [1:0]  chm;
      if (!rstn) begin
         model_reset();
         return;
      end
      dv = hq_v[0]; dd = hq_d[0];
      chm = 2'b00; mis = 0; flush = 0;
      if (dv && sv) begin
         for (int c = 0; c < 2; c++) if (dd[c*32 +: 32] != sd[c*32 +: 32]) chm[c] = 1'b1;
         mis = (chm != 2'b00);
      end else if (dv || sv) begin
         chm = 2'b11; mis = 1;
      end
      if (clr) begin
         m_pulse = 0; m_serr = 0; m_mask = 2'b00;
         if (m_st == 3) begin m_st = 0; m_sus = 0; m_run = 0; flush = 1; end
      end else begin
         m_pulse = mis;
         m_serr  = (dv != sv);
         if (mis) begin
            m_mask |= chm;
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
            if (m_st == 0 || m_st == 1) begin
               if (strict || THRESH <= 1) m_st = 3;
               else begin m_st = 2; m_sus = 1; m_run = 0; end
            end else if (m_st == 2) begin
               if (strict || m_sus + 1 >= THRESH) m_st = 3;
               else begin m_sus++; m_run = 0; end
            end
         end else if (dv && sv) begin
            if (m_st == 0) m_st = 1;
            else if (m_st == 2) begin
               m_run++;
               if (m_run == RECOVER) begin m_st = 1; m_sus = 0; m_run = 0; end
            end
         end
      end
      void'(hq_v.pop_front()); void'(hq_d.pop_front());
      if (flush) for (int i = 0; i < hq_v.size(); i++) hq_v[i] = 1'b0;
      hq_v.push_back(flush ? 1'b0 : mv); hq_d.push_back(md);
   endtask

   task automatic check_all();
      chk("fsm_state",      32'(fsm_state),      32'(m_st));
      chk("lockstep_ok",    32'(lockstep_ok),    32'(m_st == 1));
      chk("fault",          32'(fault),          32'(m_st == 3));
      chk("mismatch_pulse", 32'(mismatch_pulse), 32'(m_pulse));
      chk("sync_error",     32'(sync_error),     32'(m_serr));
      chk("fault_ch_mask",  32'(fault_ch_mask),  32'(m_mask));
      chk("mismatch_count", 32'(mismatch_count), 32'(m_cnt));
      chk("count_w4",       32'(count4),         32'(m_cnt4));
   endtask

   // One clock: shadow replays the master from DELAY cycles earlier, optionally corrupted or dropped.
   task automatic step(input bit mv, input bit corrupt, input int ch, input bit drop,
                       input bit strict, input bit clr, input bit rstn);
      logic [63:0] md, sd;
      bit sv, was_fault;
      @(negedge clk);
      md = {$urandom(), 32'hA5A5_0000 + 32'(seq)};
      seq++;
      sv = sh_v1 & ~drop;
      sd = sh_d1;
      if (corrupt) sd[ch*32] = ~sd[ch*32];
      reset = rstn; master_valid = mv; master_data = md;
      shadow_valid = sv; shadow_data = sd;
      strict_mode = strict; clear_fault = clr;
      was_fault = (m_st == 3);
      model_step(mv, md, sv, sd, strict, clr, rstn);
      if (!rstn || (clr && was_fault)) begin
         sh_v0 = 0; sh_v1 = 0;
      end else begin
         sh_v1 = sh_v0; sh_d1 = sh_d0; sh_v0 = mv; sh_d0 = md;
      end
      @(posedge clk);
      #1;
      cyc++;
      check_all();
   endtask

   initial begin
      int cnt_before;
      bit strict_r;
      sh_v0 = 0; sh_v1 = 0; sh_d0 = '0; sh_d1 = '0;
      model_reset();

      // Reset state
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("reset_state", 32'(fsm_state), 32'd0);
      chk("reset_count", 32'(mismatch_count), 32'd0);

      // 1: identical streams, shadow skewed by two cycles
      repeat (5) step(1, 0, 0, 0, 0, 0, 1);
      chk("t1_locked", 32'(fsm_state), 32'd1);
      chk("t1_nofault", 32'(fault), 32'd0);

      // 2: single ch1 bit flip, recovery after exactly RECOVER matches
      step(1, 1, 1, 0, 0, 0, 1);
      chk("t2_suspect", 32'(fsm_state), 32'd2);
      chk("t2_mask", 32'(fault_ch_mask), 32'b10);
      chk("t2_count", 32'(mismatch_count), 32'd1);
      repeat (RECOVER - 1) step(1, 0, 0, 0, 0, 0, 1);
      chk("t2_still_suspect", 32'(fsm_state), 32'd2);
      step(1, 0, 0, 0, 0, 0, 1);
      chk("t2_relocked", 32'(fsm_state), 32'd1);

      // 3: escalation to FAULT, sticky, then clear
      step(1, 1, 0, 0, 0, 0, 1);
      step(1, 1, 0, 0, 0, 0, 1);
      chk("t3_no_fault_yet", 32'(fault), 32'd0);
      step(1, 1, 0, 0, 0, 0, 1);
      chk("t3_fault", 32'(fault), 32'd1);
      repeat (4) step(1, 0, 0, 0, 0, 0, 1);
      chk("t3_sticky", 32'(fault), 32'd1);
      step(1, 0, 0, 0, 0, 1, 1);
      chk("t3_cleared_idle", 32'(fsm_state), 32'd0);
      chk("t3_cleared_mask", 32'(fault_ch_mask), 32'd0);
      repeat (3) step(1, 0, 0, 0, 0, 0, 1);
      chk("t3_relock", 32'(fsm_state), 32'd1);

      // 4: strict mode single mismatch
      step(1, 1, 0, 0, 1, 0, 1);
      chk("t4_fault", 32'(fault), 32'd1);
      chk("t4_not_ok", 32'(lockstep_ok), 32'd0);
      step(1, 0, 0, 0, 0, 1, 1);
      repeat (3) step(1, 0, 0, 0, 0, 0, 1);

      // 5: dropped shadow valid, then counter saturation on the narrow instance
      step(1, 0, 0, 1, 0, 0, 1);
      chk("t5_sync_error", 32'(sync_error), 32'd1);
      chk("t5_mask", 32'(fault_ch_mask), 32'b11);
      repeat (20) step(1, 1, $urandom_range(0, 1), 0, 0, 0, 1);
      chk("t5_saturated", 32'(count4), 32'd15);

      // 6: reset during SUSPECT, and clear coinciding with a mismatch
      step(1, 0, 0, 0, 0, 1, 1);
      repeat (3) step(1, 0, 0, 0, 0, 0, 1);
      step(1, 1, 0, 0, 0, 0, 1);
      chk("t6_suspect", 32'(fsm_state), 32'd2);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("t6_reset_state", 32'(fsm_state), 32'd0);
      chk("t6_reset_count", 32'(mismatch_count), 32'd0);
      chk("t6_reset_mask", 32'(fault_ch_mask), 32'd0);
      repeat (3) step(1, 0, 0, 0, 0, 0, 1);
      step(1, 1, 1, 0, 1, 0, 1);
      cnt_before = int'(mismatch_count);
      step(1, 1, 0, 0, 0, 1, 1);
      chk("t6_clr_idle", 32'(fsm_state), 32'd0);
      chk("t6_clr_count", 32'(mismatch_count), 32'(cnt_before));
      chk("t6_clr_pulse", 32'(mismatch_pulse), 32'd0);

      // Random traffic
      strict_r = 0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) strict_r = ~strict_r;
         step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1),
              $urandom_range(0, 15) == 0, strict_r, $urandom_range(0, 23) == 0,
              $urandom_range(0, 99) != 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
